fact_arbiter: RTL and testbench



---
 rtl/fact_pkg.sv | 14 +
 rtl/fact_arbiter_rr_pick.sv | 44 ++++
 rtl/fact_arbiter.sv | 116 +++++++++++
 tb/tb_fact_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default widths for the factorial-engine arbiter.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_XW = 4;
  localparam int DEF_RW = 32;

endpackage

// File: rtl/fact_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector by ptr,
// take the lowest set bit, rotate the winning index back.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NW = N[IW:0];

  // Both operands are below N, so one conditional subtract gives the modulo.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NW) s = s - NW;
    return s[IW-1:0];
  endfunction

  logic [N-1:0]  rot;
  logic [IW-1:0] k;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    rot   = '0;
    k     = '0;
    any   = 1'b0;
    grant = '0;
    for (int i = 0; i < N; i++) rot[i] = req[wrap_add(IW'(i), ptr)];
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k   = IW'(i);
        any = 1'b1;
      end
    end
    idx = wrap_add(k, ptr);
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fact_arbiter.sv
// Round-robin front end sharing one factorial engine between N requesters;
// results come back tagged with the owning requester id.
module fact_arbiter
  import fact_pkg::*;
#(
  parameter int N   = 4,
  parameter int XW  = DEF_XW,
  parameter int RW  = DEF_RW,
  parameter int TMO = 255,
  localparam int IW = $clog2(N),
  localparam int WW = $clog2(TMO + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    req,
  input  logic [N*XW-1:0] req_x,
  output logic [N-1:0]    gnt,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [RW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic            eng_start,
  output logic [XW-1:0]   eng_x,
  input  logic            eng_done,
  input  logic [RW-1:0]   eng_result
);

  localparam logic [WW-1:0] WD_LIMIT = TMO[WW-1:0];
  localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);

  state_t        state, state_next;
  logic [IW-1:0] ptr, id;
  logic [WW-1:0] wdog;
  logic [N-1:0]  pick_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANT;
      GRANT:   state_next = RUN;
      RUN:     if (eng_done || wdog == WD_LIMIT) state_next = DRAIN;
      DRAIN:   if (!eng_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      ptr       <= '0;
      id        <= '0;
      wdog      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= pick_grant;
            id    <= pick_idx;
            eng_x <= req_x[int'(pick_idx)*XW +: XW];
          end
        end
        GRANT: begin
          gnt       <= '0;
          eng_start <= 1'b1;
          ptr       <= (id == LAST_ID) ? '0 : id + IW'(1);
          wdog      <= '0;
        end
        RUN: begin
          if (eng_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
          end else if (wdog == WD_LIMIT) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            eng_start <= 1'b0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fact_arbiter.sv
// Randomised scoreboard bench for fact_arbiter with a behavioural engine and
// client model; grants and responses are predicted from the arbitration rules.
module tb_fact_arbiter;

  localparam int N   = 4;
  localparam int XW  = 4;
  localparam int RW  = 32;
  localparam int TMO = 24;
  localparam int IW  = $clog2(N);

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            eng_start;
  logic [XW-1:0]   eng_x;
  logic            eng_done;
  logic [RW-1:0]   eng_result;

  fact_arbiter #(.N(N), .XW(XW), .RW(RW), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_x(req_x), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .eng_start(eng_start), .eng_x(eng_x),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            id;
    logic [RW-1:0] data;
    logic          err;
  } rsp_t;

  int n_vec  = 0;
  int n_fail = 0;

  rsp_t          sb[$];
  int            glog[$];
  logic [XW-1:0] jobs[N][$];

  int eng_lat  = 20;
  int eng_rel  = 0;
  bit eng_hang = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] fact(input int x);
    longint unsigned p = 1;
    for (int k = 2; k <= x; k++) p = p * longint'(k);
    return p[RW-1:0];
  endfunction

  // First requester at or after p, wrapping; -1 when nobody asks.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add_job(input int c, input logic [XW-1:0] x);
    jobs[c].push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      ok = (req == '0) && !busy && (sb.size() == 0);
      for (int c = 0; c < N; c++) if (jobs[c].size() != 0) ok = 1'b0;
    end
    check("idle_reached", ok, 1);
  endtask

  // Client model: hold req until granted, then present the next queued job (or drop).
  initial begin
    req   = '0;
    req_x = '0;
    forever begin
      step();
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && jobs[i].size() > 0) void'(jobs[i].pop_front());
        req[i] = (jobs[i].size() > 0);
        if (jobs[i].size() > 0) req_x[i*XW +: XW] = jobs[i][0];
      end
    end
  end

  // Engine model: done after eng_lat cycles of start, held eng_rel cycles past start falling.
  initial begin
    int cnt  = 0;
    int hold = 0;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      step();
      if (eng_start && !eng_done) begin
        cnt++;
        if (!eng_hang && cnt >= eng_lat) begin
          eng_done   = 1'b1;
          eng_result = fact(int'(eng_x));
          hold       = eng_rel;
        end
      end else if (!eng_start && eng_done) begin
        if (hold == 0) begin
          eng_done = 1'b0;
          cnt      = 0;
        end else begin
          hold--;
        end
      end else if (!eng_start) begin
        cnt = 0;
      end
    end
  end

  // Monitor: predicts each grant from the sampled requests, scores each response.
  initial begin
    int            cyc = 0, start_cyc = 0, done_cyc = 0, last_done_cyc = -100;
    int            mptr = 0, e;
    logic [N-1:0]  req_last = '0, prev_gnt = '0;
    logic [N*XW-1:0] x_last = '0;
    logic [XW-1:0] exp_x;
    bit            idle_last = 1'b0, start_last = 1'b0, done_last = 1'b0;
    rsp_t          r;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        sb.delete();
        mptr = 0; req_last = '0; prev_gnt = '0;
        idle_last = 1'b0; start_last = 1'b0; done_last = 1'b0;
      end else begin
        if (eng_start && !start_last) start_cyc = cyc;
        if (eng_done && !done_last) done_cyc = cyc;
        if (eng_done) last_done_cyc = cyc;
        if (idle_last && req_last != '0) check("gnt_latency", gnt != '0, 1);
        if (gnt != '0) begin
          check("gnt_single_cycle", prev_gnt, 0);
          e = pick(req_last, mptr);
          if (e < 0) begin
            check("gnt_without_req", gnt, 0);
          end else begin
            exp_x = x_last[e*XW +: XW];
            check("gnt_onehot", gnt, N'(1) << e);
            check("eng_x", eng_x, exp_x);
            check("gnt_after_done_low", (cyc - last_done_cyc) >= 3, 1);
            r.id   = e;
            r.err  = eng_hang;
            r.data = eng_hang ? '0 : fact(int'(exp_x));
            sb.push_back(r);
            glog.push_back(e);
            mptr = (e + 1) % N;
          end
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 0);
          end else begin
            r = sb.pop_front();
            check("rsp_id", rsp_id, r.id);
            check("rsp_data", rsp_data, r.data);
            check("rsp_err", rsp_err, r.err);
            check("rsp_eng_start_low", eng_start, 0);
            if (r.err) check("wdog_latency", cyc - start_cyc, TMO + 1);
            else       check("done_to_rsp", cyc - done_cyc, 1);
          end
        end
        prev_gnt   = gnt;
        req_last   = req;
        x_last     = req_x;
        idle_last  = !busy;
        start_last = eng_start;
        done_last  = eng_done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_wrap[2]  = '{0, 3};
    int exp_rst[3]   = '{1, 3, 2};
    bit seen;

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_x}, 0);
    step();
    RST = 1'b0;

    // All four clients at once, client 0 queues a second job.
    step();
    glog.delete();
    add_job(0, 4'd3); add_job(0, 4'd6); add_job(1, 4'd4); add_job(2, 4'd7); add_job(3, 4'd1);
    wait_idle(2000);
    check("rr_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check("rr_order", glog[i], exp_order[i]);

    // Single request, engine takes 20 cycles.
    step();
    add_job(0, 4'd5);
    wait_idle(500);

    // Serve id 3, then 0 and 3 together: pointer must wrap to 0.
    step();
    add_job(3, 4'd2);
    wait_idle(500);
    step();
    glog.delete();
    add_job(0, 4'd8); add_job(3, 4'd9);
    wait_idle(1000);
    check("wrap_count", glog.size(), 2);
    for (int i = 0; i < 2 && i < glog.size(); i++) check("wrap_order", glog[i], exp_wrap[i]);

    // Engine never finishes: watchdog response.
    step();
    eng_hang = 1'b1;
    add_job(1, 4'd7);
    wait_idle(500);
    step();
    eng_hang = 1'b0;

    // Reset while the engine is running.
    add_job(2, 4'd3);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = eng_start;
    end
    check("start_seen", seen, 1);
    repeat (3) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("midrun_reset_outputs", {gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, eng_start, eng_x}, 0);
    step();
    glog.delete();
    add_job(1, 4'd4); add_job(3, 4'd6);
    wait_idle(1000);
    step();
    add_job(2, 4'd5);
    wait_idle(500);
    check("rst_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) check("rst_order", glog[i], exp_rst[i]);

    // Done held 5 cycles past start falling while client 1 waits.
    step();
    eng_lat = 6;
    eng_rel = 5;
    add_job(0, 4'd3);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = eng_done;
    end
    check("done_seen", seen, 1);
    step();
    add_job(1, 4'd6);
    wait_idle(500);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      step();
      eng_lat = $urandom_range(1, 12);
      eng_rel = $urandom_range(0, 3);
      repeat ($urandom_range(1, 3)) add_job($urandom_range(0, N - 1), XW'($urandom));
      repeat ($urandom_range(0, 15)) step();
    end
    wait_idle(8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
